// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the RAM-backed FWFT FIFO controller.
// Depth and count widths derive from the RAM address width.
package bram_fifo_ctrl_pkg;

    localparam int OBUF_DEPTH = 2;

    function automatic int depth_f(input int aw);
        return 1 << aw;
    endfunction

    function automatic int count_w_f(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/BRAM_SDP.sv
// Simple dual-port block RAM: one write port, one registered read port.
// A same-address read and write returns the old contents.
module BRAM_SDP #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO over BRAM_SDP with a 2-entry
// prefetch buffer so the head word is registered at full rate.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic                  enq_valid,
    output logic                  enq_rdy,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic                  deq_valid,
    input  logic                  deq_rdy,
    output logic [ADDR_WIDTH+1:0] count
);

    localparam int DEPTH   = depth_f(ADDR_WIDTH);
    localparam int COUNT_W = count_w_f(ADDR_WIDTH);
    localparam int RC_W    = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [RC_W-1:0]       ram_count;
    logic                  inflight;
    logic [1:0]            buf_count;
    logic [1:0]            buf_n;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_n;
    logic [DATA_WIDTH-1:0] skid;
    logic [DATA_WIDTH-1:0] skid_n;
    logic [DATA_WIDTH-1:0] q;
    logic                  flush;
    logic                  enq_fire;
    logic                  deq_fire;
    logic                  rd_en;
    logic [2:0]            pending;

    assign flush     = rst | clr;
    assign enq_rdy   = ram_count != RC_W'(DEPTH);
    assign deq_valid = buf_count != 2'd0;
    assign deq_data  = head;
    assign enq_fire  = enq_valid & enq_rdy;
    assign deq_fire  = deq_valid & deq_rdy;

    // Words that will occupy the buffer next cycle without a new issue.
    assign pending = {1'b0, buf_count} + {2'b00, inflight}
                   - {2'b00, deq_fire};
    assign rd_en   = (ram_count != '0) && (pending < 3'(OBUF_DEPTH));

    assign count = COUNT_W'(ram_count) + COUNT_W'(inflight)
                 + COUNT_W'(buf_count);

    BRAM_SDP #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (enq_fire & ~flush),
        .waddr(wr_ptr),
        .wdata(enq_data),
        .re   (rd_en & ~flush),
        .raddr(rd_ptr),
        .q    (q)
    );

    // inflight means q holds the word issued last cycle.
    always_comb begin
        head_n = head;
        skid_n = skid;
        buf_n  = buf_count;
        unique case ({deq_fire, inflight})
            2'b10: begin
                head_n = skid;
                buf_n  = buf_count - 2'd1;
            end
            2'b01: begin
                if (buf_count == 2'd0) begin
                    head_n = q;
                end else begin
                    skid_n = q;
                end
                buf_n = buf_count + 2'd1;
            end
            2'b11: begin
                if (buf_count == 2'd2) begin
                    head_n = skid;
                    skid_n = q;
                end else begin
                    head_n = q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            buf_count <= '0;
            head      <= '0;
            skid      <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            ram_count <= ram_count + RC_W'(enq_fire) - RC_W'(rd_en);
            inflight  <= rd_en;
            buf_count <= buf_n;
            head      <= head_n;
            skid      <= skid_n;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomized bench for bram_fifo_ctrl against a queue-based model.
// Checks order, occupancy, latency bound, capacity and flush behaviour.
module tb_bram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] enq_data = '0;
    logic          enq_valid = 1'b0;
    logic          enq_rdy;
    logic [DW-1:0] deq_data;
    logic          deq_valid;
    logic          deq_rdy = 1'b0;
    logic [AW+1:0] count;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    ent_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    bram_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .enq_data (enq_data),
        .enq_valid(enq_valid),
        .enq_rdy  (enq_rdy),
        .deq_data (deq_data),
        .deq_valid(deq_valid),
        .deq_rdy  (deq_rdy),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check the visible state, advance model.
    task automatic do_cycle(input logic ev, input logic dr,
                            input logic [DW-1:0] d,
                            input logic rs, input logic cl);
        logic ef;
        logic df;
        enq_valid = ev;
        deq_rdy   = dr;
        enq_data  = d;
        rst       = rs;
        clr       = cl;
        check("count", count, sb.size());
        if (sb.size() < DEPTH) check("enq_rdy_room", enq_rdy, 1);
        if (sb.size() >= DEPTH + 2) check("enq_rdy_cap", enq_rdy, 0);
        if (deq_valid) check("valid_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0 && cyc - sb[0].t >= 3)
            check("valid_latency", deq_valid, 1);
        if (hold_prev) begin
            check("hold_valid", deq_valid, 1);
            check("hold_data", deq_data, data_prev);
        end
        ef = ev & enq_rdy;
        df = deq_valid & dr;
        if (df && sb.size() > 0) check("deq_data", deq_data, sb[0].d);
        hold_prev = deq_valid & ~dr & ~rs & ~cl;
        data_prev = deq_data;
        if (rs || cl) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            if (df && sb.size() > 0) void'(sb.pop_front());
            if (ef) sb.push_back('{d: d, t: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, deq_valid, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_rdy"}, enq_rdy, 1);
        check({tag, "_data"}, deq_data, 0);
    endtask

    task automatic drain();
        for (int b = 0; b < 200 && sb.size() > 0; b++)
            do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic idle(input int n, input logic dr);
        for (int i = 0; i < n; i++)
            do_cycle(1'b0, dr, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int ep;
        int dp;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");

        // Single word latency and hold
        do_cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        check("lat_c1", deq_valid, 0);
        idle(1, 1'b0);
        check("lat_c2", deq_valid, 0);
        idle(1, 1'b0);
        check("lat_c3_valid", deq_valid, 1);
        check("lat_c3_data", deq_data, 8'hA5);
        check("lat_c3_count", count, 1);
        idle(5, 1'b0);
        check("hold5_data", deq_data, 8'hA5);
        do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("single_valid", deq_valid, 0);
        check("single_count", count, 0);

        // Fill to full capacity
        acc = 0;
        for (int b = 0; b < 40 && acc < DEPTH + 2; b++) begin
            if (enq_rdy) acc++;
            do_cycle(1'b1, 1'b0, 8'(acc), 1'b0, 1'b0);
        end
        check("full_rdy", enq_rdy, 0);
        check("full_count", count, DEPTH + 2);
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        check("full_head", deq_data, 1);
        drain();
        idle(3, 1'b1);
        check("empty_rdy", enq_rdy, 1);
        check("empty_count", count, 0);

        // Streaming with wrap
        for (int i = 0; i < 100; i++) begin
            if (i >= 3) begin
                check("stream_count", count, 3);
                check("stream_valid", deq_valid, 1);
            end
            do_cycle(1'b1, 1'b1, 8'(i + 16), 1'b0, 1'b0);
        end
        drain();
        idle(2, 1'b1);

        // Random stalls in two biased phases
        for (int i = 0; i < 5000; i++) begin
            ep = (i < 2500) ? 70 : 35;
            dp = (i < 2500) ? 35 : 70;
            do_cycle($urandom_range(0, 99) < ep,
                     $urandom_range(0, 99) < dp,
                     8'($urandom), 1'b0, 1'b0);
        end
        drain();
        idle(3, 1'b1);

        // Flush with a read in flight
        do_cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        idle(1, 1'b0);
        do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
        check("flush_valid", deq_valid, 0);
        check("flush_count", count, 0);
        idle(5, 1'b1);
        check("flush_after", deq_valid, 0);
        do_cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("post_flush_valid", deq_valid, 1);
        check("post_flush_data", deq_data, 8'h3C);
        drain();

        // Reset priority while half full
        for (int i = 0; i < DEPTH / 2; i++)
            do_cycle(1'b1, 1'b0, 8'(i + 40), 1'b0, 1'b0);
        idle(3, 1'b0);
        check("half_count", count, DEPTH / 2);
        do_cycle(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        check_zero("rst_prio");
        idle(5, 1'b1);
        check("rst_prio_after", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
